// File: rtl/pr_role_quiesce_ctrl.sv
// Role PR sequencer: gate new AXI requests, drain, decouple, grant ICAP, hold role reset, release.
// All outputs are registered (one cycle after the deciding edge); optional drain timeout via PR_DRAIN_TIMEOUT_EN.
module pr_role_quiesce_ctrl #(
    parameter int N_IF              = 3,
    parameter int CNT_W             = 6,
    parameter int RESET_HOLD_CYCLES = 64,
    parameter int DRAIN_TIMEOUT     = 4096
) (
    input  logic            CLK_IN_250,
    input  logic            AXI_RESET,
    input  logic            pr_req,
    input  logic            pr_done,
    input  logic            pr_error,
    input  logic [N_IF-1:0] wr_issue,
    input  logic [N_IF-1:0] wr_done,
    input  logic [N_IF-1:0] rd_issue,
    input  logic [N_IF-1:0] rd_done,
    output logic            block_new,
    output logic            decouple,
    output logic            role_reset,
    output logic            icap_go,
    output logic            busy,
    output logic [2:0]      state_o,
    output logic [2:0]      err_o
);
    localparam int N_CNT   = 2 * N_IF;
    localparam int TMR_MAX = (RESET_HOLD_CYCLES > DRAIN_TIMEOUT) ? RESET_HOLD_CYCLES : DRAIN_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BLOCK      = 3'd1,
        S_DECOUPLE   = 3'd2,
        S_RECONFIG   = 3'd3,
        S_RESET_HOLD = 3'd4,
        S_RELEASE    = 3'd5,
        S_FAULT      = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [CNT_W-1:0] cnt_q [N_CNT];
    logic [CNT_W-1:0] cnt_d [N_CNT];
    logic [N_CNT-1:0] issue, done;
    logic [2:0]       err_q, err_d;
    logic             ovf, unf, cnt_zero, drain, tmo;

    assign issue = {rd_issue, wr_issue};
    assign done  = {rd_done, wr_done};

    always_comb begin
        ovf      = 1'b0;
        unf      = 1'b0;
        cnt_zero = 1'b1;
        for (int i = 0; i < N_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != '0) cnt_zero = 1'b0;
            if (issue[i] && !done[i]) begin
                if (&cnt_q[i]) ovf = 1'b1;
                else           cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (done[i] && !issue[i]) begin
                if (cnt_q[i] == '0) unf = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // A request issued in the same cycle still has to be drained later.
    assign drain = cnt_zero && (issue == '0);

`ifdef PR_DRAIN_TIMEOUT_EN
    assign tmo = (tmr_q == TMR_W'(DRAIN_TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (state_q == S_IDLE && pr_req) err_d = '0;
        err_d[1] = err_d[1] | ovf;
        err_d[2] = err_d[2] | unf;
        unique case (state_q)
            S_IDLE:       if (pr_req) state_d = S_BLOCK;
            S_BLOCK: begin
                if (drain) begin
                    state_d = S_DECOUPLE;
                end else if (tmo) begin
                    state_d  = S_DECOUPLE;
                    err_d[0] = 1'b1;
                end
            end
            S_DECOUPLE:   if (tmr_q == TMR_W'(1)) state_d = S_RECONFIG;
            S_RECONFIG: begin
                if (pr_error)     state_d = S_FAULT;
                else if (pr_done) state_d = S_RESET_HOLD;
            end
            S_RESET_HOLD: if (tmr_q == TMR_W'(RESET_HOLD_CYCLES - 1)) state_d = S_RELEASE;
            S_RELEASE:    state_d = S_IDLE;
            // Role is already isolated, so a retry skips the drain.
            S_FAULT:      if (pr_req) state_d = S_DECOUPLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN_250) begin
        if (AXI_RESET) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            err_q      <= '0;
            block_new  <= 1'b0;
            decouple   <= 1'b0;
            role_reset <= 1'b0;
            icap_go    <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= (state_d != state_q) ? '0 : tmr_q + TMR_W'(1);
            err_q      <= err_d;
            block_new  <= (state_d != S_IDLE);
            decouple   <= (state_d == S_DECOUPLE) || (state_d == S_RECONFIG) ||
                          (state_d == S_RESET_HOLD) || (state_d == S_FAULT);
            role_reset <= (state_d == S_RESET_HOLD) || (state_d == S_RELEASE) || (state_d == S_FAULT);
            icap_go    <= (state_d == S_RECONFIG);
            busy       <= (state_d != S_IDLE);
            for (int i = 0; i < N_CNT; i++)
                cnt_q[i] <= (state_q == S_RELEASE) ? '0 : cnt_d[i];
        end
    end

    assign state_o = state_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_pr_role_quiesce_ctrl.sv
// Bench for pr_role_quiesce_ctrl: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_pr_role_quiesce_ctrl;
    localparam int N_IF  = 3;
    localparam int NC    = 2 * N_IF;
    localparam int CMAX  = 63;
    localparam int HOLD  = 64;
    localparam int TMO   = 4096;

    logic clk = 1'b0;
    always #2 clk = ~clk;

    logic rst = 1'b1, pr_req = 1'b0, pr_done = 1'b0, pr_error = 1'b0;
    logic [N_IF-1:0] wr_issue = '0, wr_done = '0, rd_issue = '0, rd_done = '0;
    logic block_new, decouple, role_reset, icap_go, busy;
    logic [2:0] state_o, err_o;

    pr_role_quiesce_ctrl #(.N_IF(N_IF), .CNT_W(6), .RESET_HOLD_CYCLES(HOLD), .DRAIN_TIMEOUT(TMO)) dut (
        .CLK_IN_250(clk), .AXI_RESET(rst), .pr_req(pr_req), .pr_done(pr_done), .pr_error(pr_error),
        .wr_issue(wr_issue), .wr_done(wr_done), .rd_issue(rd_issue), .rd_done(rd_done),
        .block_new(block_new), .decouple(decouple), .role_reset(role_reset), .icap_go(icap_go),
        .busy(busy), .state_o(state_o), .err_o(err_o)
    );

    int n_chk = 0, n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase number (the documented encoding), remaining dwell, outstanding counts.
    int       m_state = 0, m_left = 0, m_blk = 0;
    int       m_cnt [NC];
    bit [2:0] m_err = '0;

    always @(posedge clk) begin : model
        logic [NC-1:0] iss, dn;
        bit all0, drn;
        iss = {rd_issue, wr_issue};
        dn  = {rd_done, wr_done};
        if (rst) begin
            m_state = 0; m_left = 0; m_blk = 0; m_err = '0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            all0 = 1'b1;
            foreach (m_cnt[i]) if (m_cnt[i] != 0) all0 = 1'b0;
            drn = all0 && (iss == '0);
            if (m_state == 0 && pr_req) m_err = '0;
            for (int k = 0; k < NC; k++) begin
                if (iss[k] && !dn[k]) begin
                    if (m_cnt[k] == CMAX) m_err[1] = 1'b1; else m_cnt[k]++;
                end else if (dn[k] && !iss[k]) begin
                    if (m_cnt[k] == 0) m_err[2] = 1'b1; else m_cnt[k]--;
                end
            end
            case (m_state)
                0: if (pr_req) begin m_state = 1; m_blk = 0; end
                1: begin
                    if (drn) begin
                        m_state = 2; m_left = 2;
                    end else begin
                        m_blk++;
`ifdef PR_DRAIN_TIMEOUT_EN
                        if (m_blk == TMO) begin m_state = 2; m_left = 2; m_err[0] = 1'b1; end
`endif
                    end
                end
                2: begin m_left--; if (m_left == 0) m_state = 3; end
                3: if (pr_error) m_state = 6; else if (pr_done) begin m_state = 4; m_left = HOLD; end
                4: begin m_left--; if (m_left == 0) m_state = 5; end
                5: begin m_state = 0; foreach (m_cnt[i]) m_cnt[i] = 0; end
                6: if (pr_req) begin m_state = 2; m_left = 2; end
                default: m_state = 0;
            endcase
        end
    end

    function automatic logic [10:0] m_vec();
        logic bn, dc, rr, ig;
        bn = (m_state != 0);
        dc = (m_state == 2) || (m_state == 3) || (m_state == 4) || (m_state == 6);
        rr = (m_state == 4) || (m_state == 5) || (m_state == 6);
        ig = (m_state == 3);
        return {m_state[2:0], m_err, bn, dc, rr, ig, bn};
    endfunction

    always @(negedge clk)
        if (chk_en)
            chk("cycle", {state_o, err_o, block_new, decouple, role_reset, icap_go, busy}, m_vec());

    task automatic tick();
        @(posedge clk); #1;
        rst = 1'b0; pr_req = 1'b0; pr_done = 1'b0; pr_error = 1'b0;
        wr_issue = '0; wr_done = '0; rd_issue = '0; rd_done = '0;
    endtask

    task automatic finish_seq(input string name);
        int g;
        g = 0;
        while (!icap_go && g < 50) begin tick(); g++; end
        chk({name, "_icap"}, icap_go, 1);
        pr_done = 1'b1; tick();
        g = 0;
        while (busy && g < 100) begin tick(); g++; end
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin : stim
        int n, rr_n, dc_n;
        foreach (m_cnt[i]) m_cnt[i] = 0;

        // Reset
        rst = 1'b1; tick();
        chk("reset_out", {state_o, err_o, block_new, decouple, role_reset, icap_go, busy}, 0);
        chk_en = 1'b1;
        tick();

        // Idle drain and full sequence timing
        pr_req = 1'b1; tick();
        chk("blk_k1", {state_o, block_new, decouple}, {3'd1, 1'b1, 1'b0});
        n = 1;
        while (!icap_go && n < 20) begin tick(); n++; end
        chk("icap_latency", n, 4);
        pr_done = 1'b1; tick();
        chk("icap_drop", {icap_go, role_reset}, 2'b01);
        rr_n = 0; dc_n = 0; n = 0;
        while (role_reset && n < 200) begin
            rr_n++; if (decouple) dc_n++;
            tick(); n++;
        end
        chk("rr_len", rr_n, HOLD + 1);
        chk("dc_in_rr", dc_n, HOLD);
        chk("idle_after", {state_o, block_new, decouple, role_reset, icap_go, busy}, 0);

        // Outstanding writes on interface 0, B responses 10 cycles apart
        for (int i = 0; i < 3; i++) begin wr_issue = 3'b001; tick(); end
        pr_req = 1'b1; tick();
        for (int j = 0; j < 3; j++) begin
            repeat (9) tick();
            wr_done = 3'b001; tick();
        end
        chk("no_dec_yet", decouple, 0);
        tick();
        chk("dec_after_done", decouple, 1);
        finish_seq("outstanding");

        // Issue+done together holds the count; done+error together faults
        wr_issue = 3'b010; tick();
        pr_req = 1'b1; tick();
        tick();
        wr_issue = 3'b010; wr_done = 3'b010; tick();
        tick();
        chk("simul_hold", state_o, 1);
        wr_done = 3'b010; tick();
        n = 0;
        while (!icap_go && n < 20) begin tick(); n++; end
        pr_done = 1'b1; pr_error = 1'b1; tick();
        chk("both_fault", state_o, 6);
        repeat (3) tick();
        chk("fault_outs", {block_new, decouple, role_reset, icap_go}, 4'b1110);
        pr_req = 1'b1; tick();
        chk("fault_to_dec", state_o, 2);
        finish_seq("retry");

        // Counter saturation and underflow on read interface 2
        for (int i = 0; i < 64; i++) begin rd_issue = 3'b100; tick(); end
        chk("ovf_flag", err_o, 3'b010);
        for (int i = 0; i < 63; i++) begin rd_done = 3'b100; tick(); end
        chk("sat_at_63", err_o, 3'b010);
        rd_done = 3'b100; tick();
        chk("unf_flag", err_o, 3'b110);
        pr_req = 1'b1; tick();
        chk("err_clear", err_o, 0);
        finish_seq("limits");

        // Stuck counter: BLOCK holds
        wr_issue = 3'b001; tick();
        pr_req = 1'b1; tick();
        repeat (200) tick();
        chk("block_held", {state_o, decouple}, {3'd1, 1'b0});
        wr_done = 3'b001; tick();
        n = 0;
        while (!icap_go && n < 20) begin tick(); n++; end
        pr_error = 1'b1; tick();
        chk("err_fault", state_o, 6);

        // Reset in RECONFIG
        pr_req = 1'b1; tick();
        n = 0;
        while (!icap_go && n < 20) begin tick(); n++; end
        chk("reconfig_reached", state_o, 3);
        rst = 1'b1; tick();
        chk("rst_mid", {state_o, icap_go, decouple, role_reset, block_new}, 0);

        // Random traffic against the model
        for (int c = 0; c < 5000; c++) begin
            for (int k = 0; k < N_IF; k++) begin
                if ((m_state == 0 && $urandom_range(3) == 0) || $urandom_range(60) == 0) wr_issue[k] = 1'b1;
                if ((m_cnt[k] > 0 && $urandom_range(2) == 0) || $urandom_range(100) == 0) wr_done[k] = 1'b1;
                if ((m_state == 0 && $urandom_range(3) == 0) || $urandom_range(60) == 0) rd_issue[k] = 1'b1;
                if ((m_cnt[N_IF+k] > 0 && $urandom_range(2) == 0) || $urandom_range(100) == 0) rd_done[k] = 1'b1;
            end
            if ($urandom_range(30) == 0) pr_req = 1'b1;
            if (m_state == 3) begin
                if ($urandom_range(5) == 0) pr_done = 1'b1;
                if ($urandom_range(9) == 0) pr_error = 1'b1;
            end
            if ($urandom_range(700) == 0) rst = 1'b1;
            tick();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
